// File: rtl/lane_req_dispatcher.sv
`default_nettype none
// =============================================================================
// lane_req_dispatcher: broadcasts one request stream into per-lane FIFOs and
// merges per-lane completion reports into one done.  Rev 1.0
// =============================================================================
module lane_req_dispatcher #(
   parameter int NR_LANES   = 4,
   parameter int REQ_WIDTH  = 64,
   parameter int REQ_DEPTH  = 2,
   parameter int ID_WIDTH   = 3,
   parameter int DONE_DEPTH = 2
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          req_valid_i,
   output logic                          req_ready_o,
   input  logic [REQ_WIDTH-1:0]          req_i,
   output logic [NR_LANES-1:0]           lane_req_valid_o,
   input  logic [NR_LANES-1:0]           lane_req_ready_i,
   output logic [NR_LANES*REQ_WIDTH-1:0] lane_req_o,
   input  logic [NR_LANES-1:0]           lane_done_valid_i,
   output logic [NR_LANES-1:0]           lane_done_ready_o,
   input  logic [NR_LANES*ID_WIDTH-1:0]  lane_done_id_i,
   output logic                          done_valid_o,
   input  logic                          done_ready_i,
   output logic [ID_WIDTH-1:0]           done_id_o,
   output logic                          id_mismatch_o
);
   localparam int RPTR_W = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
   localparam int RCNT_W = $clog2(REQ_DEPTH + 1);
   localparam int DPTR_W = (DONE_DEPTH > 1) ? $clog2(DONE_DEPTH) : 1;
   localparam int DCNT_W = $clog2(DONE_DEPTH + 1);

   localparam logic [RPTR_W-1:0] R_LAST = RPTR_W'(REQ_DEPTH - 1);
   localparam logic [RCNT_W-1:0] R_FULL = RCNT_W'(REQ_DEPTH);
   localparam logic [DPTR_W-1:0] D_LAST = DPTR_W'(DONE_DEPTH - 1);
   localparam logic [DCNT_W-1:0] D_FULL = DCNT_W'(DONE_DEPTH);

   logic [NR_LANES-1:0] req_room;
   logic                req_push;
   logic [NR_LANES-1:0] done_present;
   logic                done_pop;
   logic [ID_WIDTH-1:0] done_head [NR_LANES];
   logic                id_diff;

   // Ready looks only at registered counts, so upstream never sees lane ready.
   assign req_ready_o  = &req_room;
   assign req_push     = req_valid_i & req_ready_o;
   assign done_valid_o = &done_present;
   assign done_pop     = done_valid_o & done_ready_i;
   assign done_id_o    = done_head[0];

   for (genvar i = 0; i < NR_LANES; i++) begin : g_lane
      logic [REQ_WIDTH-1:0] req_mem [REQ_DEPTH];
      logic [RPTR_W-1:0]    req_wptr;
      logic [RPTR_W-1:0]    req_rptr;
      logic [RCNT_W-1:0]    req_cnt;
      logic                 req_pop;
      logic [ID_WIDTH-1:0]  done_mem [DONE_DEPTH];
      logic [DPTR_W-1:0]    done_wptr;
      logic [DPTR_W-1:0]    done_rptr;
      logic [DCNT_W-1:0]    done_cnt;
      logic                 done_push;

      assign req_room[i]         = (req_cnt < R_FULL);
      assign lane_req_valid_o[i] = (req_cnt != '0);
      assign lane_req_o[i*REQ_WIDTH +: REQ_WIDTH] = req_mem[req_rptr];
      assign req_pop             = lane_req_valid_o[i] & lane_req_ready_i[i];

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            req_wptr <= '0;
            req_rptr <= '0;
            req_cnt  <= '0;
         end else begin
            if (req_push) req_wptr <= (req_wptr == R_LAST) ? '0 : req_wptr + RPTR_W'(1);
            if (req_pop)  req_rptr <= (req_rptr == R_LAST) ? '0 : req_rptr + RPTR_W'(1);
            if (req_push && !req_pop)      req_cnt <= req_cnt + RCNT_W'(1);
            else if (!req_push && req_pop) req_cnt <= req_cnt - RCNT_W'(1);
         end
      end

      always_ff @(posedge clk_i) begin
         if (req_push) req_mem[req_wptr] <= req_i;
      end

      assign lane_done_ready_o[i] = (done_cnt < D_FULL);
      assign done_present[i]      = (done_cnt != '0);
      assign done_head[i]         = done_mem[done_rptr];
      assign done_push            = lane_done_valid_i[i] & lane_done_ready_o[i];

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            done_wptr <= '0;
            done_rptr <= '0;
            done_cnt  <= '0;
         end else begin
            if (done_push) done_wptr <= (done_wptr == D_LAST) ? '0 : done_wptr + DPTR_W'(1);
            if (done_pop)  done_rptr <= (done_rptr == D_LAST) ? '0 : done_rptr + DPTR_W'(1);
            if (done_push && !done_pop)      done_cnt <= done_cnt + DCNT_W'(1);
            else if (!done_push && done_pop) done_cnt <= done_cnt - DCNT_W'(1);
         end
      end

      always_ff @(posedge clk_i) begin
         if (done_push) done_mem[done_wptr] <= lane_done_id_i[i*ID_WIDTH +: ID_WIDTH];
      end
   end

   always_comb begin
      id_diff = 1'b0;
      for (int k = 1; k < NR_LANES; k++) begin
         if (done_head[k] != done_head[0]) id_diff = 1'b1;
      end
   end

   // Sticky until reset; merged dones keep flowing after a mismatch.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                  id_mismatch_o <= 1'b0;
      else if (done_pop && id_diff) id_mismatch_o <= 1'b1;
   end

endmodule
`default_nettype wire

// File: tb/tb_lane_req_dispatcher.sv
`default_nettype none
// tb_lane_req_dispatcher: directed scenarios plus randomized traffic checked
// against a queue-based model of the dispatcher.
module tb_lane_req_dispatcher;
   localparam int NL = 4;
   localparam int RW = 64;
   localparam int RD = 2;
   localparam int IW = 3;
   localparam int DD = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             req_valid;
   logic             req_ready;
   logic [RW-1:0]    req;
   logic [NL-1:0]    lane_req_valid;
   logic [NL-1:0]    lane_req_ready;
   logic [NL*RW-1:0] lane_req;
   logic [NL-1:0]    lane_done_valid;
   logic [NL-1:0]    lane_done_ready;
   logic [NL*IW-1:0] lane_done_id;
   logic             done_valid;
   logic             done_ready;
   logic [IW-1:0]    done_id;
   logic             id_mismatch;

   int checks = 0;
   int passed = 0;

   logic [RW-1:0] mq [NL][$];
   logic [IW-1:0] dq [NL][$];

   lane_req_dispatcher #(
      .NR_LANES(NL), .REQ_WIDTH(RW), .REQ_DEPTH(RD), .ID_WIDTH(IW), .DONE_DEPTH(DD)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_i(req),
      .lane_req_valid_o(lane_req_valid), .lane_req_ready_i(lane_req_ready), .lane_req_o(lane_req),
      .lane_done_valid_i(lane_done_valid), .lane_done_ready_o(lane_done_ready),
      .lane_done_id_i(lane_done_id),
      .done_valid_o(done_valid), .done_ready_i(done_ready), .done_id_o(done_id),
      .id_mismatch_o(id_mismatch)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      req_valid       = 1'b0;
      req             = '0;
      lane_req_ready  = '1;
      lane_done_valid = '0;
      lane_done_id    = '0;
      done_ready      = 1'b0;
   endtask

   function automatic logic [RW-1:0] lane_pl(input int i);
      return lane_req[i*RW +: RW];
   endfunction

   task automatic test_reset;
      idle();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %0b want 1", req_ready); else passed++;
      checks++; if (lane_req_valid !== '0) $display("FAIL reset_lane_valid: got %b want 0000", lane_req_valid); else passed++;
      checks++; if (done_valid !== 1'b0 || id_mismatch !== 1'b0)
         $display("FAIL reset_done: got dv=%0b mm=%0b want 0 0", done_valid, id_mismatch); else passed++;
      checks++; if (lane_done_ready !== '1) $display("FAIL reset_done_ready: got %b want 1111", lane_done_ready); else passed++;
      rst_n = 1'b1;
      tick();
      checks++; if (req_ready !== 1'b1 || lane_req_valid !== '0 || done_valid !== 1'b0)
         $display("FAIL post_reset: got rr=%0b lv=%b dv=%0b want 1 0000 0", req_ready, lane_req_valid, done_valid); else passed++;
   endtask

   task automatic test_broadcast;
      req_valid = 1'b1;
      req       = 64'h11;
      checks++; if (lane_req_valid !== '0) $display("FAIL bc_no_early_valid: got %b want 0000", lane_req_valid); else passed++;
      tick();
      req_valid = 1'b0;
      checks++; if (lane_req_valid !== '1) $display("FAIL bc_valid: got %b want 1111", lane_req_valid); else passed++;
      checks++; if (lane_req !== {NL{64'h11}}) $display("FAIL bc_payload: got %h want all 11", lane_req); else passed++;
      tick();
      checks++; if (lane_req_valid !== '0 || req_ready !== 1'b1)
         $display("FAIL bc_drain: got lv=%b rr=%0b want 0000 1", lane_req_valid, req_ready); else passed++;
   endtask

   task automatic test_skew;
      lane_req_ready = 4'b1011;
      req_valid = 1'b1;
      req = 64'h01;
      checks++; if (req_ready !== 1'b1) $display("FAIL skew_ready0: got %0b want 1", req_ready); else passed++;
      tick();
      req = 64'h02;
      tick();
      req = 64'h03;
      checks++; if (req_ready !== 1'b0) $display("FAIL skew_stall: got %0b want 0", req_ready); else passed++;
      checks++; if (lane_pl(2) !== 64'h01) $display("FAIL skew_l2_head: got %h want 01", lane_pl(2)); else passed++;
      checks++; if (lane_pl(0) !== 64'h02) $display("FAIL skew_l0_head: got %h want 02", lane_pl(0)); else passed++;
      tick();
      checks++; if (lane_req_valid !== 4'b0100 || req_ready !== 1'b0)
         $display("FAIL skew_only_l2: got lv=%b rr=%0b want 0100 0", lane_req_valid, req_ready); else passed++;
      lane_req_ready = '1;
      tick();
      checks++; if (req_ready !== 1'b1) $display("FAIL skew_ready_back: got %0b want 1", req_ready); else passed++;
      checks++; if (lane_pl(2) !== 64'h02 || lane_req_valid !== 4'b0100)
         $display("FAIL skew_l2_second: got %h lv=%b want 02 0100", lane_pl(2), lane_req_valid); else passed++;
      tick();
      req_valid = 1'b0;
      checks++; if (lane_req_valid !== '1 || lane_pl(2) !== 64'h03 || lane_pl(0) !== 64'h03)
         $display("FAIL skew_third: got lv=%b l2=%h l0=%h want 1111 03 03", lane_req_valid, lane_pl(2), lane_pl(0)); else passed++;
      tick();
      checks++; if (lane_req_valid !== '0) $display("FAIL skew_drain: got %b want 0000", lane_req_valid); else passed++;
   endtask

   task automatic test_full_pop;
      lane_req_ready = '0;
      req_valid = 1'b1;
      req = 64'hA0;
      tick();
      req = 64'hA1;
      tick();
      checks++; if (req_ready !== 1'b0) $display("FAIL full_ready: got %0b want 0", req_ready); else passed++;
      lane_req_ready = '1;
      req = 64'hA2;
      tick();
      checks++; if (req_ready !== 1'b1 || lane_pl(0) !== 64'hA1)
         $display("FAIL full_pop_no_push: got rr=%0b head=%h want 1 a1", req_ready, lane_pl(0)); else passed++;
      tick();
      req_valid = 1'b0;
      checks++; if (lane_req_valid !== '1 || lane_pl(0) !== 64'hA2)
         $display("FAIL full_next_push: got lv=%b head=%h want 1111 a2", lane_req_valid, lane_pl(0)); else passed++;
      tick();
      checks++; if (lane_req_valid !== '0) $display("FAIL full_drain: got %b want 0000", lane_req_valid); else passed++;
   endtask

   task automatic test_done_stagger;
      int t [NL] = '{3, 7, 4, 10};
      idle();
      lane_done_id = {NL{IW'(5)}};
      for (int c = 0; c <= 12; c++) begin
         checks++; if (done_valid !== (c >= 11))
            $display("FAIL stagger_valid_c%0d: got %0b want %0b", c, done_valid, (c >= 11)); else passed++;
         for (int i = 0; i < NL; i++) lane_done_valid[i] = (c == t[i]);
         tick();
      end
      checks++; if (done_valid !== 1'b1 || done_id !== IW'(5))
         $display("FAIL stagger_hold: got dv=%0b id=%0d want 1 5", done_valid, done_id); else passed++;
      done_ready = 1'b1;
      tick();
      done_ready = 1'b0;
      checks++; if (done_valid !== 1'b0 || id_mismatch !== 1'b0)
         $display("FAIL stagger_pop: got dv=%0b mm=%0b want 0 0", done_valid, id_mismatch); else passed++;
   endtask

   task automatic test_done_backpressure;
      idle();
      lane_done_valid = 4'b1110;
      lane_done_id = {NL{IW'(1)}};
      tick();
      lane_done_id = {NL{IW'(2)}};
      tick();
      lane_done_valid = '0;
      checks++; if (lane_done_ready !== 4'b0001 || done_valid !== 1'b0)
         $display("FAIL bp_full: got dr=%b dv=%0b want 0001 0", lane_done_ready, done_valid); else passed++;
      lane_done_valid = 4'b0001;
      lane_done_id = {NL{IW'(1)}};
      tick();
      checks++; if (done_valid !== 1'b1 || done_id !== IW'(1))
         $display("FAIL bp_first: got dv=%0b id=%0d want 1 1", done_valid, done_id); else passed++;
      lane_done_id = {NL{IW'(2)}};
      done_ready = 1'b1;
      tick();
      lane_done_valid = '0;
      checks++; if (done_valid !== 1'b1 || done_id !== IW'(2) || lane_done_ready !== 4'b1111)
         $display("FAIL bp_second: got dv=%0b id=%0d dr=%b want 1 2 1111", done_valid, done_id, lane_done_ready); else passed++;
      tick();
      done_ready = 1'b0;
      checks++; if (done_valid !== 1'b0 || lane_done_ready[3] !== 1'b1)
         $display("FAIL bp_drained: got dv=%0b dr3=%0b want 0 1", done_valid, lane_done_ready[3]); else passed++;
   endtask

   task automatic test_mismatch;
      idle();
      lane_done_id = {IW'(5), IW'(5), IW'(6), IW'(5)};
      lane_done_valid = '1;
      tick();
      lane_done_valid = '0;
      checks++; if (done_valid !== 1'b1 || done_id !== IW'(5) || id_mismatch !== 1'b0)
         $display("FAIL mm_pending: got dv=%0b id=%0d mm=%0b want 1 5 0", done_valid, done_id, id_mismatch); else passed++;
      done_ready = 1'b1;
      tick();
      done_ready = 1'b0;
      checks++; if (id_mismatch !== 1'b1 || done_valid !== 1'b0)
         $display("FAIL mm_set: got mm=%0b dv=%0b want 1 0", id_mismatch, done_valid); else passed++;
      lane_done_id = {NL{IW'(2)}};
      lane_done_valid = '1;
      done_ready = 1'b1;
      tick();
      lane_done_valid = '0;
      tick();
      done_ready = 1'b0;
      checks++; if (id_mismatch !== 1'b1 || done_valid !== 1'b0)
         $display("FAIL mm_sticky: got mm=%0b dv=%0b want 1 0", id_mismatch, done_valid); else passed++;
   endtask

   task automatic test_async_reset;
      idle();
      lane_req_ready = '0;
      req_valid = 1'b1;
      req = 64'h55;
      tick();
      req_valid = 1'b0;
      lane_done_valid = '1;
      tick();
      lane_done_valid = '0;
      checks++; if (lane_req_valid !== '1 || done_valid !== 1'b1 || id_mismatch !== 1'b1)
         $display("FAIL ar_pre: got lv=%b dv=%0b mm=%0b want 1111 1 1", lane_req_valid, done_valid, id_mismatch); else passed++;
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (lane_req_valid !== '0 || done_valid !== 1'b0 || id_mismatch !== 1'b0)
         $display("FAIL ar_immediate: got lv=%b dv=%0b mm=%0b want 0000 0 0", lane_req_valid, done_valid, id_mismatch); else passed++;
      checks++; if (req_ready !== 1'b1 || lane_done_ready !== '1)
         $display("FAIL ar_ready: got rr=%0b dr=%b want 1 1111", req_ready, lane_done_ready); else passed++;
      tick();
      rst_n = 1'b1;
      idle();
      tick();
      checks++; if (lane_req_valid !== '0 || done_valid !== 1'b0)
         $display("FAIL ar_discarded: got lv=%b dv=%0b want 0000 0", lane_req_valid, done_valid); else passed++;
   endtask

   task automatic test_random;
      bit mism;
      bit exp_rr, exp_dv, acc, dpop;
      logic [NL-1:0] exp_lv, exp_dr;
      logic [IW-1:0] flip;
      int seq [NL];
      mism = 1'b0;
      for (int i = 0; i < NL; i++) begin
         mq[i].delete();
         dq[i].delete();
         seq[i] = 0;
      end
      idle();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      for (int c = 0; c < 400; c++) begin
         exp_rr = 1'b1;
         exp_dv = 1'b1;
         for (int i = 0; i < NL; i++) begin
            exp_rr    &= (mq[i].size() < RD);
            exp_lv[i]  = (mq[i].size() != 0);
            exp_dr[i]  = (dq[i].size() < DD);
            exp_dv    &= (dq[i].size() != 0);
         end
         checks++; if (req_ready !== exp_rr) $display("FAIL rnd_req_ready c%0d: got %0b want %0b", c, req_ready, exp_rr); else passed++;
         checks++; if (lane_req_valid !== exp_lv) $display("FAIL rnd_lane_valid c%0d: got %b want %b", c, lane_req_valid, exp_lv); else passed++;
         for (int i = 0; i < NL; i++) begin
            if (exp_lv[i]) begin
               checks++; if (lane_pl(i) !== mq[i][0])
                  $display("FAIL rnd_payload c%0d lane%0d: got %h want %h", c, i, lane_pl(i), mq[i][0]); else passed++;
            end
         end
         checks++; if (lane_done_ready !== exp_dr) $display("FAIL rnd_done_ready c%0d: got %b want %b", c, lane_done_ready, exp_dr); else passed++;
         checks++; if (done_valid !== exp_dv) $display("FAIL rnd_done_valid c%0d: got %0b want %0b", c, done_valid, exp_dv); else passed++;
         if (exp_dv) begin
            checks++; if (done_id !== dq[0][0]) $display("FAIL rnd_done_id c%0d: got %0d want %0d", c, done_id, dq[0][0]); else passed++;
         end
         checks++; if (id_mismatch !== mism) $display("FAIL rnd_mismatch c%0d: got %0b want %0b", c, id_mismatch, mism); else passed++;

         req_valid  = ($urandom_range(0, 3) != 0);
         req        = {$urandom, $urandom};
         done_ready = ($urandom_range(0, 1) == 1);
         for (int i = 0; i < NL; i++) begin
            lane_req_ready[i]  = ($urandom_range(0, 2) != 0);
            lane_done_valid[i] = ($urandom_range(0, 2) == 0);
            flip = ($urandom_range(0, 63) == 0) ? IW'(1) : IW'(0);
            lane_done_id[i*IW +: IW] = IW'(seq[i]) ^ flip;
         end

         acc  = req_valid && exp_rr;
         dpop = exp_dv && done_ready;
         if (dpop) begin
            for (int i = 1; i < NL; i++) if (dq[i][0] != dq[0][0]) mism = 1'b1;
         end
         for (int i = 0; i < NL; i++) begin
            if (exp_lv[i] && lane_req_ready[i]) void'(mq[i].pop_front());
            if (acc) mq[i].push_back(req);
            if (dpop) void'(dq[i].pop_front());
            if (lane_done_valid[i] && exp_dr[i]) begin
               dq[i].push_back(lane_done_id[i*IW +: IW]);
               seq[i]++;
            end
         end
         tick();
      end
      idle();
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      test_reset();
      test_broadcast();
      test_skew();
      test_full_pop();
      test_done_stagger();
      test_done_backpressure();
      test_mismatch();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
`default_nettype wire
